if_fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC, issues word fetches to instruction memory (one outstanding request), and presents instruction / PC+4 to IF/ID. Honours pipeline stall from hazard detection and redirects (branch/jump/flush) from EX. Stale in-flight responses are discarded after a redirect.

---
 rtl/riscv_pkg.sv | 7 +
 rtl/if_fetch_stage_if.sv | 10 +
 rtl/if_fetch_stage_hold_buf.sv | 24 ++
 rtl/if_fetch_stage.sv | 109 ++++++++++
 tb/tb_if_fetch_stage.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch FSM states, default width.
package riscv_pkg;
  localparam int          XLEN_DEFAULT    = 32;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction memory port: one request per cycle, response with latency of at least 1.
interface if_fetch_stage_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fetch_stage_hold_buf.sv
// One-entry buffer parking a fetched instruction while the pipeline is stalled.
module if_fetch_stage_hold_buf
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din,
  output logic        vld,
  output logic [31:0] dout
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      dout <= NOP_INSTRUCTION;
    end else if (clear) begin
      vld  <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      dout <= din;
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, keeps one imem request in flight, feeds IF/ID.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_pipeline,
  input  logic                  redirect,
  input  logic [XLEN-1:0]       redirect_target,
  if_fetch_stage_if.master      imem,
  output logic                  fetch_valid_out,
  output logic [31:0]           instruction_out,
  output logic [XLEN-1:0]       pc_plus_4_out
);
  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, pc_inc;
  logic            hold_load, hold_clear, hold_vld;
  logic [31:0]     hold_instr;
  logic            req_c;
  logic            unused_tgt_lsb;

  assign pc_inc         = pc + XLEN'(4);
  assign unused_tgt_lsb = ^redirect_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= {RESET_PC[XLEN-1:2], 2'b00};
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  if_fetch_stage_hold_buf u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hold_load),
    .clear (hold_clear),
    .din   (imem.imem_rdata),
    .vld   (hold_vld),
    .dout  (hold_instr)
  );

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    req_c           = 1'b0;
    imem.imem_addr  = pc;
    fetch_valid_out = 1'b0;
    instruction_out = NOP_INSTRUCTION;
    pc_plus_4_out   = '0;
    hold_load       = 1'b0;
    hold_clear      = 1'b0;

    if (redirect) begin
      // Redirect wins over stall and any response arriving this cycle.
      pc_nxt     = {redirect_target[XLEN-1:2], 2'b00};
      hold_clear = 1'b1;
      if ((state == WAIT || state == DROP) && !imem.imem_rvalid)
        state_nxt = DROP;
      else
        state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          req_c     = 1'b1;
          state_nxt = WAIT;
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (!stall_pipeline) begin
              fetch_valid_out = 1'b1;
              instruction_out = imem.imem_rdata;
              pc_plus_4_out   = pc_inc;
              req_c           = 1'b1;
              imem.imem_addr  = pc_inc;
              pc_nxt          = pc_inc;
            end else begin
              hold_load = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          fetch_valid_out = hold_vld;
          instruction_out = hold_instr;
          pc_plus_4_out   = pc_inc;
          if (!stall_pipeline) begin
            // IF/ID captures the held word at this edge; refetch next cycle.
            pc_nxt     = pc_inc;
            hold_clear = 1'b1;
            state_nxt  = IDLE;
          end
        end
        DROP: begin
          if (imem.imem_rvalid) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // IDLE is the reset state; keep the port quiet while reset is held.
  assign imem.imem_req = req_c & rst_n;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: hand-driven memory responses per cycle.
module tb_if_fetch_stage;
  import riscv_pkg::*;

  logic        clk, rst_n;
  logic        stall, redirect;
  logic [31:0] redirect_target;
  logic        fv;
  logic [31:0] instr, pc4;

  logic        w_stall, w_redir;
  logic [31:0] w_tgt;
  logic        w_fv;
  logic [31:0] w_instr, w_pc4;

  int checks, errs;

  if_fetch_stage_if #(.XLEN(32)) m ();
  if_fetch_stage_if #(.XLEN(32)) w ();

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_pipeline  (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem            (m),
    .fetch_valid_out (fv),
    .instruction_out (instr),
    .pc_plus_4_out   (pc4)
  );

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_pipeline  (w_stall),
    .redirect        (w_redir),
    .redirect_target (w_tgt),
    .imem            (w),
    .fetch_valid_out (w_fv),
    .instruction_out (w_instr),
    .pc_plus_4_out   (w_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rv, input logic [31:0] rd, input logic st,
                        input logic re, input logic [31:0] tg);
    m.imem_rvalid   = rv;
    m.imem_rdata    = rd;
    stall           = st;
    redirect        = re;
    redirect_target = tg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_in(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_req",   {31'h0, m.imem_req}, 32'h0);
    chk("rst_fv",    {31'h0, fv},         32'h0);
    chk("rst_instr", instr,               NOP_INSTRUCTION);
    chk("rst_pc4",   pc4,                 32'h0);
    @(posedge clk);
    #1;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errs   = 0;
    rst_n  = 1'b0;
    w_stall = 1'b0;
    w_redir = 1'b0;
    w_tgt   = 32'h0;
    w.imem_rvalid = 1'b0;
    w.imem_rdata  = 32'h0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Latency-1 streaming, then stall on the word at 0x8.
    do_reset();
    @(negedge clk);
    chk("t1_req0",  {31'h0, m.imem_req}, 32'h1);
    chk("t1_addr0", m.imem_addr,         32'h0);
    chk("t1_fv0",   {31'h0, fv},         32'h0);
    tick();
    set_in(1'b1, 32'h0010_0093, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t1_fv1",    {31'h0, fv},         32'h1);
    chk("t1_instr1", instr,               32'h0010_0093);
    chk("t1_pc4_1",  pc4,                 32'h4);
    chk("t1_req1",   {31'h0, m.imem_req}, 32'h1);
    chk("t1_addr1",  m.imem_addr,         32'h4);
    tick();
    set_in(1'b1, 32'h0020_0113, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t1_fv2",   {31'h0, fv}, 32'h1);
    chk("t1_pc4_2", pc4,         32'h8);
    chk("t1_addr2", m.imem_addr, 32'h8);
    tick();
    set_in(1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("t2_cap_fv",  {31'h0, fv},         32'h0);
    chk("t2_cap_req", {31'h0, m.imem_req}, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("t2_hold_fv",    {31'h0, fv},         32'h1);
      chk("t2_hold_instr", instr,               32'h0050_0093);
      chk("t2_hold_pc4",   pc4,                 32'hC);
      chk("t2_hold_req",   {31'h0, m.imem_req}, 32'h0);
      tick();
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t2_rel_fv",    {31'h0, fv}, 32'h1);
    chk("t2_rel_instr", instr,       32'h0050_0093);
    chk("t2_rel_req",   {31'h0, m.imem_req}, 32'h0);
    tick();
    @(negedge clk);
    chk("t2_next_req",  {31'h0, m.imem_req}, 32'h1);
    chk("t2_next_addr", m.imem_addr,         32'hC);
    chk("t2_next_fv",   {31'h0, fv},         32'h0);
    tick();

    // Redirect with a latency-3 request in flight: stale word must vanish.
    do_reset();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
    @(negedge clk);
    chk("t3_redir_req", {31'h0, m.imem_req}, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t3_addr10", m.imem_addr, 32'h10);
    tick();
    @(negedge clk);
    chk("t3_bubble_fv", {31'h0, fv}, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    @(negedge clk);
    chk("t3_r2_fv",  {31'h0, fv},         32'h0);
    chk("t3_r2_req", {31'h0, m.imem_req}, 32'h0);
    tick();
    set_in(1'b1, 32'hBAD0_0010, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t3_drop_fv",    {31'h0, fv},         32'h0);
    chk("t3_drop_instr", instr,               NOP_INSTRUCTION);
    chk("t3_drop_req",   {31'h0, m.imem_req}, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t3_new_req",  {31'h0, m.imem_req}, 32'h1);
    chk("t3_new_addr", m.imem_addr,         32'h100);
    tick();

    // Redirect to an unaligned target coincident with rvalid and stall.
    set_in(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h203);
    @(negedge clk);
    chk("t4_fv",    {31'h0, fv},         32'h0);
    chk("t4_instr", instr,               NOP_INSTRUCTION);
    chk("t4_pc4",   pc4,                 32'h0);
    chk("t4_req",   {31'h0, m.imem_req}, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t4_next_fv",   {31'h0, fv},         32'h0);
    chk("t4_next_req",  {31'h0, m.imem_req}, 32'h1);
    chk("t4_next_addr", m.imem_addr,         32'h200);
    tick();

    // PC wrap on the second instance.
    do_reset();
    @(negedge clk);
    chk("t5_addr0", w.imem_addr, 32'hFFFF_FFF8);
    tick();
    w.imem_rvalid = 1'b1;
    w.imem_rdata  = 32'h0000_0013;
    @(negedge clk);
    chk("t5_fv1",   {31'h0, w_fv}, 32'h1);
    chk("t5_pc4_1", w_pc4,         32'hFFFF_FFFC);
    chk("t5_addr1", w.imem_addr,   32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("t5_pc4_2", w_pc4,       32'h0);
    chk("t5_addr2", w.imem_addr, 32'h0);
    tick();
    w.imem_rvalid = 1'b0;

    // Reset pulse mid-WAIT; the late response must be ignored.
    do_reset();
    @(negedge clk);
    chk("t6_addr0", m.imem_addr, 32'h0);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    set_in(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t6_fv",    {31'h0, fv},         32'h0);
    chk("t6_instr", instr,               NOP_INSTRUCTION);
    chk("t6_pc4",   pc4,                 32'h0);
    chk("t6_req",   {31'h0, m.imem_req}, 32'h1);
    chk("t6_addr",  m.imem_addr,         32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t6_wait_fv",  {31'h0, fv},         32'h0);
    chk("t6_wait_req", {31'h0, m.imem_req}, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
